// File: rtl/bram_stream_loader_if.sv
// rtl/bram_stream_loader_if.sv - control, CPU byte link and BRAM write port of the stream loader
interface bram_stream_loader_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_BYTES = 3
);
  logic                      sig_on;
  logic                      sig_done;
  logic                      sig_error;
  logic [ADDR_WIDTH:0]       words_written;
  logic [ADDR_WIDTH-1:0]     bram_addr_w;
  logic [DATA_BYTES*8-1:0]   bram_data_in;
  logic                      bram_en_w;
  logic                      restart;
  logic [7:0]                init_index;
  logic [7:0]                init_aux_info;
  logic                      request_data;
  logic                      data_ready;
  logic [7:0]                cpu_data_in;
  logic                      transmit_finished;
  logic [7:0]                song_selection;

  modport master (
    input  sig_on, data_ready, cpu_data_in, transmit_finished, song_selection,
    output sig_done, sig_error, words_written, bram_addr_w, bram_data_in, bram_en_w,
           restart, init_index, init_aux_info, request_data
  );

  modport slave (
    output sig_on, data_ready, cpu_data_in, transmit_finished, song_selection,
    input  sig_done, sig_error, words_written, bram_addr_w, bram_data_in, bram_en_w,
           restart, init_index, init_aux_info, request_data
  );
endinterface

// File: rtl/bram_stream_loader.sv
// rtl/bram_stream_loader.sv - packs a CPU byte stream into BRAM words with watchdog retry and overflow guard
module bram_stream_loader #(
  parameter int         ADDR_WIDTH           = 13,
  parameter int         DATA_BYTES           = 3,
  parameter bit         BIG_ENDIAN           = 1'b0,
  parameter logic [7:0] STATIC_INIT_AUX_INFO = 8'h00,
  parameter int         RESTARTING_TIMEOUT   = 5,
  parameter int         WATCHDOG_CYCLES      = 1000,
  parameter int         MAX_RETRIES          = 2
) (
  input logic                  CLK,
  input logic                  RESET,
  bram_stream_loader_if.master bus
);

  localparam int LW  = ($clog2(DATA_BYTES + 1) > 0) ? $clog2(DATA_BYTES + 1) : 1;
  localparam int RTW = ($clog2(RESTARTING_TIMEOUT + 1) > 0) ? $clog2(RESTARTING_TIMEOUT + 1) : 1;
  localparam int WDW = ($clog2(WATCHDOG_CYCLES + 1) > 0) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
  localparam int RW  = ($clog2(MAX_RETRIES + 1) > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {IDLE, RESTART, RECV, WRITE, FLUSH, DONE} state_t;

  state_t                  state, state_next;
  logic [LW-1:0]           lane_cnt;
  logic [LW-1:0]           lane_pos;
  logic [DATA_BYTES*8-1:0] word_buf;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    addr_full;
  logic [ADDR_WIDTH:0]     words_written;
  logic                    sig_error;
  logic [7:0]              init_index;
  logic [RTW-1:0]          rst_cnt;
  logic [WDW-1:0]          wd_cnt;
  logic [RW-1:0]           retry_cnt;

  logic rst_last, lane_last, wd_expired, retry_left;

  assign rst_last   = (rst_cnt == RTW'(RESTARTING_TIMEOUT - 1));
  assign lane_last  = (lane_cnt == LW'(DATA_BYTES - 1));
  assign wd_expired = (wd_cnt == WDW'(WATCHDOG_CYCLES - 1));
  assign retry_left = (retry_cnt < RW'(MAX_RETRIES));
  assign lane_pos   = BIG_ENDIAN ? (LW'(DATA_BYTES - 1) - lane_cnt) : lane_cnt;

  assign bus.bram_addr_w   = addr;
  assign bus.bram_data_in  = word_buf;
  assign bus.words_written = words_written;
  assign bus.sig_error     = sig_error;
  assign bus.init_index    = init_index;
  assign bus.init_aux_info = STATIC_INIT_AUX_INFO;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    bus.restart      = 1'b0;
    bus.request_data = 1'b0;
    bus.bram_en_w    = 1'b0;
    bus.sig_done     = 1'b0;
    case (state)
      IDLE: if (bus.sig_on) state_next = RESTART;
      RESTART: begin
        bus.restart = (rst_cnt == '0);
        if (rst_last) state_next = RECV;
      end
      RECV: begin
        bus.request_data = 1'b1;
        // A byte arriving with transmit_finished is consumed before the finish is acted on.
        if (bus.data_ready) begin
          if (addr_full)                  state_next = DONE;
          else if (lane_last)             state_next = WRITE;
          else if (bus.transmit_finished) state_next = FLUSH;
        end else if (bus.transmit_finished) begin
          state_next = (lane_cnt != '0) ? FLUSH : DONE;
        end else if (wd_expired) begin
          state_next = retry_left ? RESTART : DONE;
        end
      end
      WRITE: begin
        bus.bram_en_w = 1'b1;
        state_next    = RECV;
      end
      FLUSH: begin
        bus.bram_en_w = 1'b1;
        state_next    = DONE;
      end
      DONE: begin
        bus.sig_done = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lane_cnt      <= '0;
      word_buf      <= '0;
      addr          <= '0;
      addr_full     <= 1'b0;
      words_written <= '0;
      sig_error     <= 1'b0;
      init_index    <= '0;
      rst_cnt       <= '0;
      wd_cnt        <= '0;
      retry_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sig_on) begin
            init_index    <= bus.song_selection;
            words_written <= '0;
            sig_error     <= 1'b0;
            retry_cnt     <= '0;
            rst_cnt       <= '0;
          end
        end
        RESTART: begin
          if (rst_last) begin
            rst_cnt   <= '0;
            lane_cnt  <= '0;
            word_buf  <= '0;
            addr      <= '0;
            addr_full <= 1'b0;
            wd_cnt    <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        RECV: begin
          if (bus.data_ready) begin
            wd_cnt <= '0;
            if (addr_full) begin
              sig_error <= 1'b1;
            end else begin
              word_buf[{lane_pos, 3'b000} +: 8] <= bus.cpu_data_in;
              lane_cnt                          <= lane_cnt + 1'b1;
            end
          end else if (!bus.transmit_finished) begin
            if (wd_expired) begin
              wd_cnt <= '0;
              if (retry_left) begin
                retry_cnt     <= retry_cnt + 1'b1;
                words_written <= '0;
              end else begin
                sig_error <= 1'b1;
              end
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
        end
        WRITE, FLUSH: begin
          words_written <= words_written + 1'b1;
          lane_cnt      <= '0;
          word_buf      <= '0;
          // The top address is written once; the next byte then trips the overflow error.
          if (addr == {ADDR_WIDTH{1'b1}}) addr_full <= 1'b1;
          else                            addr      <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_loader.sv
// tb/tb_bram_stream_loader.sv - directed bench for bram_stream_loader
module tb_bram_stream_loader;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       sig_on_main = 1'b0;
  logic       sig_on_ov = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] cpu_data = 8'h00;
  logic       tf = 1'b0;
  logic [7:0] song = 8'h00;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  bram_stream_loader_if #(.ADDR_WIDTH(13), .DATA_BYTES(3)) if_le ();
  bram_stream_loader_if #(.ADDR_WIDTH(13), .DATA_BYTES(3)) if_be ();
  bram_stream_loader_if #(.ADDR_WIDTH(2),  .DATA_BYTES(1)) if_ov ();

  assign if_le.sig_on = sig_on_main;
  assign if_be.sig_on = sig_on_main;
  assign if_ov.sig_on = sig_on_ov;
  assign if_le.data_ready = data_ready;
  assign if_be.data_ready = data_ready;
  assign if_ov.data_ready = data_ready;
  assign if_le.cpu_data_in = cpu_data;
  assign if_be.cpu_data_in = cpu_data;
  assign if_ov.cpu_data_in = cpu_data;
  assign if_le.transmit_finished = tf;
  assign if_be.transmit_finished = tf;
  assign if_ov.transmit_finished = tf;
  assign if_le.song_selection = song;
  assign if_be.song_selection = song;
  assign if_ov.song_selection = song;

  bram_stream_loader #(.ADDR_WIDTH(13), .DATA_BYTES(3), .BIG_ENDIAN(1'b0), .STATIC_INIT_AUX_INFO(8'h00),
                       .RESTARTING_TIMEOUT(5), .WATCHDOG_CYCLES(20), .MAX_RETRIES(2))
    u_le (.CLK(CLK), .RESET(RESET), .bus(if_le.master));
  bram_stream_loader #(.ADDR_WIDTH(13), .DATA_BYTES(3), .BIG_ENDIAN(1'b1), .STATIC_INIT_AUX_INFO(8'h00),
                       .RESTARTING_TIMEOUT(5), .WATCHDOG_CYCLES(20), .MAX_RETRIES(2))
    u_be (.CLK(CLK), .RESET(RESET), .bus(if_be.master));
  bram_stream_loader #(.ADDR_WIDTH(2), .DATA_BYTES(1), .BIG_ENDIAN(1'b0), .STATIC_INIT_AUX_INFO(8'hA5),
                       .RESTARTING_TIMEOUT(5), .WATCHDOG_CYCLES(1000), .MAX_RETRIES(2))
    u_ov (.CLK(CLK), .RESET(RESET), .bus(if_ov.master));

  logic [31:0] wa_le[$], wdat_le[$], wa_be[$], wdat_be[$], wa_ov[$], wdat_ov[$];
  int rs_cyc[$];
  int rs_le = 0, rs_be = 0, dn_le = 0, dn_be = 0, dn_ov = 0;

  always @(negedge CLK) begin
    if (if_le.bram_en_w) begin
      wa_le.push_back(32'(if_le.bram_addr_w));
      wdat_le.push_back(32'(if_le.bram_data_in));
    end
    if (if_be.bram_en_w) begin
      wa_be.push_back(32'(if_be.bram_addr_w));
      wdat_be.push_back(32'(if_be.bram_data_in));
    end
    if (if_ov.bram_en_w) begin
      wa_ov.push_back(32'(if_ov.bram_addr_w));
      wdat_ov.push_back(32'(if_ov.bram_data_in));
    end
    if (if_le.restart) begin
      rs_le = rs_le + 1;
      rs_cyc.push_back(cyc);
    end
    if (if_be.restart) rs_be = rs_be + 1;
    if (if_le.sig_done) dn_le = dn_le + 1;
    if (if_be.sig_done) dn_be = dn_be + 1;
    if (if_ov.sig_done) dn_ov = dn_ov + 1;
  end

  int b_wle, b_wbe, b_wov, b_rle, b_rbe, b_dle, b_dbe, b_dov, b_rc;
  logic [23:0] exp1_le [4] = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_wle = wa_le.size(); b_wbe = wa_be.size(); b_wov = wa_ov.size();
    b_rle = rs_le; b_rbe = rs_be; b_rc = rs_cyc.size();
    b_dle = dn_le; b_dbe = dn_be; b_dov = dn_ov;
  endtask

  task automatic pulse_on(input bit ov, input logic [7:0] s);
    song = s;
    if (ov) sig_on_ov = 1'b1;
    else    sig_on_main = 1'b1;
    @(posedge CLK); #1;
    sig_on_ov = 1'b0;
    sig_on_main = 1'b0;
    song = 8'hEE;
  endtask

  task automatic wait_req(input bit ov);
    int k = 0;
    while (!(ov ? if_ov.request_data : if_le.request_data) && k < 50) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("request_data_timeout", k < 50, 1'b1);
  endtask

  task automatic wait_done(input bit ov, input int limit);
    int k = 0;
    while ((ov ? (dn_ov == b_dov) : (dn_le == b_dle)) && k < limit) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("sig_done_timeout", k < limit, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    data_ready = 1'b1;
    cpu_data = b;
    @(posedge CLK); #1;
    data_ready = 1'b0;
    repeat (gap) begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ww", if_le.words_written, 0);
    chk("rst_en", if_le.bram_en_w, 0);
    chk("rst_restart", if_le.restart, 0);
    chk("rst_req", if_le.request_data, 0);
    chk("rst_done", if_le.sig_done, 0);
    chk("rst_err", if_le.sig_error, 0);
    chk("rst_addr", if_le.bram_addr_w, 0);
    chk("rst_aux_le", if_le.init_aux_info, 8'h00);
    chk("rst_aux_ov", if_ov.init_aux_info, 8'hA5);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // 12 bytes, growing gaps, both byte orders in lockstep
    snap();
    pulse_on(1'b0, 8'h07);
    wait_req(1'b0);
    for (int i = 1; i <= 12; i++) send_byte(8'(i), i);
    tf = 1'b1;
    wait_done(1'b0, 20);
    tf = 1'b0;
    chk("t1_restart_le", rs_le - b_rle, 1);
    chk("t1_restart_be", rs_be - b_rbe, 1);
    chk("t1_index", if_le.init_index, 8'h07);
    chk("t1_nwr", wa_le.size() - b_wle, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", wa_le[b_wle+i], i);
      chk("t1_data_le", wdat_le[b_wle+i], exp1_le[i]);
    end
    chk("t1_be_first", wdat_be[b_wbe], 24'h010203);
    chk("t1_be_last", wdat_be[b_wbe+3], 24'h0A0B0C);
    chk("t1_done_le", dn_le - b_dle, 1);
    chk("t1_done_be", dn_be - b_dbe, 1);
    chk("t1_err", if_le.sig_error, 0);
    chk("t1_ww", if_le.words_written, 4);

    // 7 bytes: partial final word is zero padded
    snap();
    pulse_on(1'b0, 8'h03);
    wait_req(1'b0);
    for (int i = 1; i <= 7; i++) send_byte(8'(i), 2);
    tf = 1'b1;
    wait_done(1'b0, 20);
    tf = 1'b0;
    chk("t2_nwr", wa_le.size() - b_wle, 3);
    chk("t2_last_addr", wa_le[b_wle+2], 2);
    chk("t2_last_le", wdat_le[b_wle+2], 24'h000007);
    chk("t2_last_be", wdat_be[b_wbe+2], 24'h070000);
    chk("t2_ww", if_le.words_written, 3);
    chk("t2_index", if_le.init_index, 8'h03);

    // address overflow on a 4-word BRAM with 1-byte words
    snap();
    pulse_on(1'b1, 8'h11);
    wait_req(1'b1);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 2);
    repeat (3) @(posedge CLK);
    #1;
    chk("t3_nwr", wa_ov.size() - b_wov, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_addr", wa_ov[b_wov+i], i);
      chk("t3_data", wdat_ov[b_wov+i], i + 1);
    end
    chk("t3_err", if_ov.sig_error, 1);
    chk("t3_done", dn_ov - b_dov, 1);
    chk("t3_ww", if_ov.words_written, 4);

    // silent CPU: watchdog retries twice then errors
    snap();
    pulse_on(1'b0, 8'h05);
    wait_done(1'b0, 300);
    chk("t4_restarts", rs_le - b_rle, 3);
    chk("t4_gap1", rs_cyc[b_rc+1] - rs_cyc[b_rc], 25);
    chk("t4_gap2", rs_cyc[b_rc+2] - rs_cyc[b_rc+1], 25);
    chk("t4_err", if_le.sig_error, 1);
    chk("t4_done", dn_le - b_dle, 1);
    chk("t4_nwr", wa_le.size() - b_wle, 0);
    chk("t4_ww", if_le.words_written, 0);

    // reset in the middle of the word at addr 1, then a clean reload
    snap();
    pulse_on(1'b0, 8'h06);
    wait_req(1'b0);
    chk("t5_err_cleared", if_le.sig_error, 0);
    send_byte(8'h01, 2);
    send_byte(8'h02, 2);
    send_byte(8'h03, 2);
    send_byte(8'h04, 1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("t5_ww", if_le.words_written, 0);
    chk("t5_en", if_le.bram_en_w, 0);
    chk("t5_addr", if_le.bram_addr_w, 0);
    chk("t5_data", if_le.bram_data_in, 0);
    chk("t5_req", if_le.request_data, 0);
    chk("t5_restart", if_le.restart, 0);
    chk("t5_index", if_le.init_index, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("t5_no_done", dn_le - b_dle, 0);
    chk("t5_nwr_before", wa_le.size() - b_wle, 1);
    snap();
    pulse_on(1'b0, 8'h09);
    wait_req(1'b0);
    send_byte(8'h09, 2);
    send_byte(8'h08, 2);
    send_byte(8'h07, 2);
    tf = 1'b1;
    wait_done(1'b0, 20);
    tf = 1'b0;
    chk("t5_nwr", wa_le.size() - b_wle, 1);
    chk("t5_re_addr", wa_le[b_wle], 0);
    chk("t5_re_data", wdat_le[b_wle], 24'h070809);
    chk("t5_re_ww", if_le.words_written, 1);
    chk("t5_re_err", if_le.sig_error, 0);
    chk("t5_re_index", if_le.init_index, 8'h09);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bram_stream_loader.md
Name: bram_stream_loader

Overview:
Parametrised successor of the BRAM data loader. It pulls a byte stream from the CPU link and packs bytes into words of DATA_BYTES bytes, then writes them to a BRAM write port. Over the base loader it adds:
- selectable byte order
- padding of a partial final word
- address-overflow protection
- an inactivity watchdog with bounded automatic restart
- an error status
It sits between the CPU transfer link and the song/beatmap BRAM inside core.

Parameters:
ADDR_WIDTH, 13, BRAM word-address width.
DATA_BYTES, 3, bytes per BRAM word (1..8).
BIG_ENDIAN, 0, 0 = first byte in bits [7:0]; 1 = first byte in the MSB lane.
STATIC_INIT_AUX_INFO, 8'h00, value driven on init_aux_info.
RESTARTING_TIMEOUT, 5, cycles the block waits in RESTART after pulsing restart.
WATCHDOG_CYCLES, 1000, idle cycles in RECV (no data_ready) before a retry.
MAX_RETRIES, 2, automatic restarts allowed before an error is reported.

Ports:
CLK  in  1  clock, rising edge.
RESET  in  1  synchronous, active-high reset.
sig_on  in  1  start pulse; ignored unless the block is in IDLE.
sig_done  out  1  one-cycle pulse at the end of a load (success or error).
sig_error  out  1  held high after a failed load until the next sig_on or RESET.
words_written  out  ADDR_WIDTH+1  number of words written in the current or last load.
bram_addr_w  out  ADDR_WIDTH  BRAM write address.
bram_data_in  out  DATA_BYTES*8  BRAM write data.
bram_en_w  out  1  BRAM write enable, one cycle per word.
restart  out  1  one-cycle request to the CPU to begin transmitting.
init_index  out  8  song index, latched from song_selection on an accepted sig_on.
init_aux_info  out  8  constant STATIC_INIT_AUX_INFO.
request_data  out  1  high while the block is in RECV.
data_ready  in  1  one-cycle strobe: cpu_data_in is valid.
cpu_data_in  in  8  byte from the CPU.
transmit_finished  in  1  level: the CPU has no more bytes.
song_selection  in  8  song to load.

Behaviour:
- Reset values:
  - all outputs 0, except init_aux_info = STATIC_INIT_AUX_INFO;
  - state IDLE; byte lane counter 0; retry counter 0.
- RESET wins over every other input in the same cycle. Asserting it mid-load aborts the load with no sig_done.
- States: IDLE, RESTART, RECV, WRITE, FLUSH, DONE.
- IDLE, on sig_on:
  - latch init_index = song_selection;
  - clear words_written, sig_error and the retry counter;
  - go to RESTART.
- RESTART:
  - restart is high for the first cycle only;
  - the block waits RESTARTING_TIMEOUT cycles total, with data_ready ignored;
  - lane counter and the address are cleared, then the state goes to RECV.
- RECV (request_data = 1):
  - On data_ready, the byte is stored in lane k (k = lane counter) and k increments.
  - When k reaches DATA_BYTES, the state goes to WRITE.
  - Byte placement: BIG_ENDIAN = 0 puts lane k at bits [8k+7:8k]; BIG_ENDIAN = 1 puts it at bits [8(DATA_BYTES-1-k)+7 : 8(DATA_BYTES-1-k)].
- WRITE (one cycle):
  - bram_en_w = 1, bram_addr_w = current address, bram_data_in = packed word;
  - then address+1, words_written+1, lane counter 0, return to RECV.
- Latency: the byte that completes a word is captured on edge N; bram_en_w is high during cycle N+1.
- data_ready in a non-RECV cycle is dropped. The CPU must wait at least 1 cycle between strobes, and request_data is low during WRITE.
- transmit_finished seen in RECV:
  - If it coincides with data_ready, the byte is accepted first.
  - If the lane counter is nonzero, go to FLUSH: unfilled lanes are zero, one write occurs, then DONE.
  - Otherwise go directly to DONE.
- Overflow:
  - After the word at address 2^ADDR_WIDTH-1 is written, the address does not wrap.
  - Any further byte sets sig_error, and the state goes to DONE without a write.
- Watchdog:
  - A counter runs in RECV and resets on each data_ready.
  - At WATCHDOG_CYCLES: if retries < MAX_RETRIES, retries+1, words_written is cleared and the state goes to RESTART (the whole transfer repeats).
  - Otherwise sig_error = 1 and the state goes to DONE.
- DONE: sig_done = 1 for one cycle, then IDLE. words_written and sig_error hold until the next sig_on.

Test Plan:
- DATA_BYTES=3, BIG_ENDIAN=0. Sequence:
  - sig_on with song_selection=8'h07;
  - 12 bytes 1..12 sent, with gaps of 1..12 cycles between strobes;
  - transmit_finished asserted.

  Required response:
  - restart is one pulse and init_index=7;
  - 4 writes: addr 0..3 with data 24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A;
  - sig_done one pulse, sig_error=0, words_written=4.
- Same stimulus with BIG_ENDIAN=1 -> the first word is 24'h010203 and the last is 24'h0A0B0C.
- 7 bytes (1..7), then transmit_finished -> 3 writes, the last being 24'h000007 at addr 2; words_written=3.
- ADDR_WIDTH=2, DATA_BYTES=1, 6 bytes sent -> writes at addr 0..3 only; the 5th byte sets sig_error=1 and sig_done pulses; no further bram_en_w.
- WATCHDOG_CYCLES=20, MAX_RETRIES=2, CPU silent after sig_on -> three restart pulses, spaced 1 + RESTARTING_TIMEOUT-1 + 20 cycles apart; then sig_error=1 and sig_done pulses.
- RESET raised for 1 cycle in the middle of the word at addr 1 -> all outputs 0 on the next cycle with no sig_done. A fresh sig_on then reloads from addr 0 correctly.
